// File: rtl/prbs_seq_ctrl.sv
// Step/load sequencer for an 8-bit PRBS generator: debounced single-step, divided free-run,
// fixed-length bursts and all-zero lock-up recovery. All outputs are registered.
module prbs_seq_ctrl #(
   parameter int unsigned      WIDTH        = 8,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int unsigned      DB_CYC       = 20000,
   parameter int unsigned      RUN_DIV      = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_step,
   input  logic             run_en,
   input  logic             burst_start,
   input  logic [7:0]       burst_len,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic [WIDTH-1:0] lfsr_state,
   output logic             lfsr_step,
   output logic             lfsr_load,
   output logic [WIDTH-1:0] lfsr_seed,
   output logic             busy,
   output logic [1:0]       state_o,
   output logic [15:0]      step_count,
   output logic             lockup_err
);

   localparam int unsigned DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
   localparam int unsigned RDW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYC - 1);
   localparam logic [RDW-1:0] DIV_LAST = RDW'(RUN_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_BURST = 2'd3
   } state_t;

   state_t           state_q;
   logic [1:0]       sync_q;
   logic             db_lvl_q;
   logic [DBW-1:0]   db_cnt_q;
   logic             press_q;
   logic [RDW-1:0]   div_q;
   logic [7:0]       burst_q;
   logic             step_q;
   logic             load_q;
   logic             load_prev_q;
   logic [WIDTH-1:0] seed_q;
   logic [15:0]      count_q;
   logic             lockerr_q;
   logic             busy_q;

   logic             run_tick_d;
   logic [RDW-1:0]   div_d;
   logic             lockup_d;

   assign run_tick_d = (div_q == DIV_LAST);
   assign div_d      = run_tick_d ? {RDW{1'b0}} : div_q + RDW'(1);
   // A zero state right after a load is the generator still settling, not a lock-up.
   assign lockup_d   = (lfsr_state == {WIDTH{1'b0}}) && (state_q != ST_LOAD) && !load_prev_q;

   // Synchroniser and debouncer: one press pulse per accepted rising level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 2'b00;
         db_lvl_q <= 1'b0;
         db_cnt_q <= {DBW{1'b0}};
         press_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_step};
         press_q <= 1'b0;
         if (sync_q[1] == db_lvl_q) begin
            db_cnt_q <= {DBW{1'b0}};
         end else if (db_cnt_q == DB_LAST) begin
            db_cnt_q <= {DBW{1'b0}};
            db_lvl_q <= sync_q[1];
            press_q  <= sync_q[1];
         end else begin
            db_cnt_q <= db_cnt_q + DBW'(1);
         end
      end
   end

   // Sequencer FSM; every output is decided here one cycle ahead and held in a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_LOAD;
         step_q      <= 1'b0;
         load_q      <= 1'b0;
         load_prev_q <= 1'b0;
         seed_q      <= DEFAULT_SEED;
         count_q     <= 16'd0;
         lockerr_q   <= 1'b0;
         div_q       <= {RDW{1'b0}};
         burst_q     <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         load_prev_q <= load_q;
         step_q      <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         if (seed_load) begin
            state_q   <= ST_LOAD;
            seed_q    <= seed_in;
            load_q    <= 1'b1;
            lockerr_q <= 1'b0;
            count_q   <= 16'd0;
            div_q     <= {RDW{1'b0}};
            burst_q   <= 8'd0;
         end else if (lockup_d) begin
            state_q   <= ST_LOAD;
            seed_q    <= DEFAULT_SEED;
            load_q    <= 1'b1;
            lockerr_q <= 1'b1;
            count_q   <= 16'd0;
            div_q     <= {RDW{1'b0}};
            burst_q   <= 8'd0;
         end else begin
            case (state_q)
               // Out of reset LOAD lasts one extra cycle so the load pulse is registered.
               ST_LOAD: begin
                  count_q <= 16'd0;
                  if (load_q) begin
                     state_q <= ST_IDLE;
                  end else begin
                     load_q <= 1'b1;
                  end
               end
               ST_IDLE: begin
                  if (burst_start && (burst_len != 8'd0)) begin
                     state_q <= ST_BURST;
                     burst_q <= burst_len - 8'd1;
                     step_q  <= 1'b1;
                     busy_q  <= 1'b1;
                     count_q <= count_q + 16'd1;
                  end else if (run_en) begin
                     state_q <= ST_RUN;
                     div_q   <= div_d;
                     if (run_tick_d) begin
                        step_q  <= 1'b1;
                        count_q <= count_q + 16'd1;
                     end else begin
                        step_q  <= 1'b0;
                     end
                  end else if (press_q) begin
                     step_q  <= 1'b1;
                     count_q <= count_q + 16'd1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_RUN: begin
                  if (!run_en) begin
                     state_q <= ST_IDLE;
                     div_q   <= {RDW{1'b0}};
                  end else begin
                     div_q <= div_d;
                     if (run_tick_d) begin
                        step_q  <= 1'b1;
                        count_q <= count_q + 16'd1;
                     end else begin
                        step_q  <= 1'b0;
                     end
                  end
               end
               ST_BURST: begin
                  if (burst_q == 8'd0) begin
                     state_q <= ST_IDLE;
                  end else begin
                     burst_q <= burst_q - 8'd1;
                     step_q  <= 1'b1;
                     busy_q  <= 1'b1;
                     count_q <= count_q + 16'd1;
                  end
               end
               default: begin
                  state_q <= ST_LOAD;
                  load_q  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign lfsr_step  = step_q;
   assign lfsr_load  = load_q;
   assign lfsr_seed  = seed_q;
   assign busy       = busy_q;
   assign state_o    = state_q;
   assign step_count = count_q;
   assign lockup_err = lockerr_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl with DB_CYC=4 and RUN_DIV=3.
module tb_prbs_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_step;
   logic        run_en;
   logic        burst_start;
   logic [7:0]  burst_len;
   logic        seed_load;
   logic [7:0]  seed_in;
   logic [7:0]  lfsr_state;
   logic        lfsr_step;
   logic        lfsr_load;
   logic [7:0]  lfsr_seed;
   logic        busy;
   logic [1:0]  state_o;
   logic [15:0] step_count;
   logic        lockup_err;

   int n_tests = 0;
   int n_fail  = 0;
   int steps;
   int busys;

   prbs_seq_ctrl #(.WIDTH(8), .DEFAULT_SEED(8'h01), .DB_CYC(4), .RUN_DIV(3)) dut (
      .clk(clk), .rst(rst), .btn_step(btn_step), .run_en(run_en),
      .burst_start(burst_start), .burst_len(burst_len), .seed_load(seed_load),
      .seed_in(seed_in), .lfsr_state(lfsr_state), .lfsr_step(lfsr_step),
      .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .busy(busy), .state_o(state_o),
      .step_count(step_count), .lockup_err(lockup_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and sample just after the edge, tallying step/busy cycles.
   task automatic tick();
      @(posedge clk);
      #1;
      if (lfsr_step) steps++;
      if (busy) busys++;
      if (lfsr_step && lfsr_load) begin
         n_tests++;
         n_fail++;
         $display("FAIL step_and_load: got both high expected exclusive");
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; btn_step = 1'b0; run_en = 1'b0; burst_start = 1'b0;
      burst_len = 8'd0; seed_load = 1'b0; seed_in = 8'h00; lfsr_state = 8'h5A;
      steps = 0; busys = 0;
      ticks(3);
      rst = 1'b0;
      check("rst_state", 32'(state_o), 32'd1);
      check("rst_load", 32'(lfsr_load), 32'd0);
      check("rst_seed", 32'(lfsr_seed), 32'h01);
      check("rst_count", 32'(step_count), 32'd0);
      check("rst_busy_lock", 32'({busy, lockup_err, lfsr_step}), 32'd0);
      tick();
      check("post_rst_load", 32'({lfsr_load, state_o}), 32'b101);
      check("post_rst_seed", 32'(lfsr_seed), 32'h01);
      tick();
      check("post_rst_idle", 32'({lfsr_load, state_o}), 32'b000);
      check("post_rst_count", 32'(step_count), 32'd0);

      // Debounce: three single-cycle glitches, then two genuine presses.
      steps = 0;
      for (int g = 0; g < 3; g++) begin
         btn_step = 1'b1; tick(); btn_step = 1'b0; ticks(5);
      end
      check("glitch_steps", 32'(steps), 32'd0);
      btn_step = 1'b1; ticks(10); btn_step = 1'b0; ticks(8);
      check("press1_steps", 32'(steps), 32'd1);
      btn_step = 1'b1; ticks(10); btn_step = 1'b0; ticks(8);
      check("press2_steps", 32'(steps), 32'd2);
      check("press_count", 32'(step_count), 32'd2);

      // Seed load clears the count.
      seed_in = 8'h3C; seed_load = 1'b1; tick(); seed_load = 1'b0;
      check("seed3c_load", 32'({lfsr_load, state_o}), 32'b101);
      check("seed3c_val", 32'(lfsr_seed), 32'h3C);
      check("seed3c_count", 32'(step_count), 32'd0);
      tick();

      // Zero-length burst is ignored.
      steps = 0; burst_len = 8'd0; burst_start = 1'b1; tick(); burst_start = 1'b0; ticks(4);
      check("burst0_steps", 32'(steps), 32'd0);
      check("burst0_state", 32'(state_o), 32'd0);

      // Burst of 5 with a second burst_start mid-way.
      steps = 0; busys = 0; burst_len = 8'd5; burst_start = 1'b1; tick(); burst_start = 1'b0;
      check("burst_first", 32'({lfsr_step, busy, state_o}), 32'b1111);
      tick();
      burst_len = 8'd9; burst_start = 1'b1; tick(); burst_start = 1'b0;
      ticks(7);
      check("burst_steps", 32'(steps), 32'd5);
      check("burst_busy", 32'(busys), 32'd5);
      check("burst_count", 32'(step_count), 32'd5);
      check("burst_end_state", 32'(state_o), 32'd0);

      // Free-run: 12 cycles at RUN_DIV=3 give 4 steps, none after run_en drops.
      steps = 0; run_en = 1'b1; ticks(6);
      check("run_state", 32'(state_o), 32'd2);
      ticks(6);
      check("run_steps", 32'(steps), 32'd4);
      run_en = 1'b0; steps = 0; ticks(8);
      check("run_off_steps", 32'(steps), 32'd0);
      check("run_off_state", 32'(state_o), 32'd0);
      check("run_count", 32'(step_count), 32'd9);

      // Lock-up recovery, then a user seed clears the error.
      lfsr_state = 8'h00; tick(); lfsr_state = 8'h5A;
      check("lock_load", 32'({lfsr_load, state_o}), 32'b101);
      check("lock_seed", 32'(lfsr_seed), 32'h01);
      check("lock_err", 32'(lockup_err), 32'd1);
      ticks(2);
      check("lock_sticky", 32'({lockup_err, state_o}), 32'b100);
      seed_in = 8'hA5; seed_load = 1'b1; tick(); seed_load = 1'b0;
      check("a5_load", 32'({lfsr_load, state_o}), 32'b101);
      check("a5_seed", 32'(lfsr_seed), 32'hA5);
      check("a5_err", 32'(lockup_err), 32'd0);
      tick();

      // Abort a 10-step burst with seed_load during its third cycle.
      steps = 0; burst_len = 8'd10; burst_start = 1'b1; tick(); burst_start = 1'b0;
      tick();
      seed_in = 8'h77; seed_load = 1'b1; tick(); seed_load = 1'b0;
      check("abort_load", 32'({lfsr_load, lfsr_step, busy, state_o}), 32'b10001);
      check("abort_seed", 32'(lfsr_seed), 32'h77);
      check("abort_count", 32'(step_count), 32'd0);
      ticks(12);
      check("abort_steps", 32'(steps), 32'd2);
      check("abort_state", 32'(state_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
